// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR burst controller: command encodings, FSM
// state types and the mode-register code helper.
package ddr_pkg;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;

  localparam int A10 = 10;

  typedef enum logic [3:0] {
    I_WAIT, I_CKE, I_PRE1, I_EMRS, I_MRS1, I_PRE2, I_REF1, I_REF2, I_MRS2, I_DONE
  } init_state_e;

  typedef enum logic [2:0] {
    M_IDLE, M_ACT, M_WRITE, M_READ, M_RECOVER, M_PRE, M_REFRESH
  } main_state_e;

  // A[6:0] of the final mode register write: {CAS code, sequential, BL code}
  function automatic logic [6:0] mode_code(input int burst_len, input int cas_lat);
    logic [2:0] bl;
    case (burst_len)
      2:       bl = 3'b001;
      8:       bl = 3'b011;
      default: bl = 3'b010;
    endcase
    return {3'(cas_lat), 1'b0, bl};
  endfunction

endpackage

// File: rtl/ddr_refresh_timer.sv
// Free-running refresh interval timer; raises a sticky pending flag at each
// terminal count and clears it when the controller reports the refresh done.
module ddr_refresh_timer
  import ddr_pkg::*;
#(
  parameter int REFI = 1040
) (
  input  logic clk133,
  input  logic rstN,
  input  logic i_en,
  input  logic i_done,
  output logic o_pending
);

  localparam int CNT_W = $clog2(REFI + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             w_tc;

  assign w_tc      = i_en && (r_cnt == '0);
  assign o_pending = r_pending;

  // Reload on terminal count so the period is independent of bus activity
  always_ff @(posedge clk133 or negedge rstN) begin
    if (!rstN) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      if (!i_en || w_tc) r_cnt <= CNT_W'(REFI - 1);
      else               r_cnt <= r_cnt - CNT_W'(1);

      if (!i_en)       r_pending <= 1'b0;
      else if (w_tc)   r_pending <= 1'b1;
      else if (i_done) r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr_burst_controller.sv
// DDR SDRAM command sequencer: power-up init, closed-page burst reads/writes,
// periodic auto-refresh. Define AUTO_PRECHARGE_EN to use WR/RD with auto-precharge.
//
// state     | meaning
// I_WAIT    | power-up wait, CKE low
// I_CKE     | CKE high, NOPs before first PRE
// I_PRE1/2  | precharge all
// I_EMRS    | extended mode register (DLL enable)
// I_MRS1/2  | mode register (DLL reset / final burst+CAS setup)
// I_REF1/2  | init auto-refreshes
// I_DONE    | init complete, main FSM runs
// M_IDLE    | wait for request or refresh
// M_ACT     | row activate, wait T_RCD
// M_WRITE   | WR issued, write words handed over
// M_READ    | RD issued, burst on bus
// M_RECOVER | write recovery (or full auto-precharge recovery)
// M_PRE     | precharge bank, wait T_RP
// M_REFRESH | auto-refresh, wait T_RFC
module ddr_burst_controller
  import ddr_pkg::*;
#(
  parameter int ROW_W     = 13,
  parameter int COL_W     = 10,
  parameter int BANK_W    = 2,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4,
  parameter int CAS_LAT   = 2,
  parameter int T_RP      = 3,
  parameter int T_MRD     = 2,
  parameter int T_RFC     = 11,
  parameter int T_RCD     = 3,
  parameter int T_WR      = 3,
  parameter int REFI      = 1040,
  parameter int INIT_WAIT = 26600
) (
  input  logic                          clk133,
  input  logic                          rstN,
  input  logic                          reqValid,
  output logic                          reqReady,
  input  logic                          reqWrite,
  input  logic [BANK_W+ROW_W+COL_W-1:0] reqAddr,
  input  logic [DATA_W-1:0]             wrData,
  output logic                          wrReady,
  output logic [DATA_W-1:0]             rdData,
  output logic                          rdValid,
  output logic                          initDone,
  output logic [2:0]                    sdCmd,
  output logic [ROW_W-1:0]              sdA,
  output logic [BANK_W-1:0]             sdBA,
  output logic                          sdCKE,
  output logic                          sdCS,
  output logic                          phyWrEn,
  output logic [DATA_W-1:0]             phyWrData,
  output logic                          phyRdEn,
  input  logic [DATA_W-1:0]             phyRdData
);

  localparam int HALF_BL = BURST_LEN / 2;
  localparam int PWR_W   = $clog2(INIT_WAIT + 1);
  localparam int TMR_W   = 8;
`ifdef AUTO_PRECHARGE_EN
  localparam logic AP = 1'b1;
`else
  localparam logic AP = 1'b0;
`endif

  init_state_e       r_init_st, w_init_nx;
  main_state_e       r_main_st, w_main_nx;
  logic [TMR_W-1:0]  r_tmr, w_dwell;
  logic [PWR_W-1:0]  r_pwr_cnt;
  logic              r_first;
  logic              r_write;
  logic [BANK_W-1:0] r_bank;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic              r_phy_wr_en;
  logic [DATA_W-1:0] r_phy_wr_data;
  logic [CAS_LAT-1:0] r_rd_dl;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_done, w_tc, w_change, w_accept, w_wr_ready, w_rd_burst;
  logic              w_ref_pending, w_ref_done;

  assign w_done     = (r_init_st == I_DONE);
  assign w_tc       = (r_tmr == '0);
  assign w_accept   = reqValid && reqReady;
  assign w_wr_ready = w_done && (r_main_st == M_WRITE);
  assign w_rd_burst = w_done && (r_main_st == M_READ);
  assign w_ref_done = w_done && (r_main_st == M_REFRESH) && w_tc;
  assign w_change   = (w_init_nx != r_init_st) || (w_main_nx != r_main_st);

  ddr_refresh_timer #(.REFI(REFI)) u_ref (
    .clk133    (clk133),
    .rstN      (rstN),
    .i_en      (w_done),
    .i_done    (w_ref_done),
    .o_pending (w_ref_pending)
  );

  always_ff @(posedge clk133 or negedge rstN) begin
    if (!rstN) begin
      r_init_st <= I_WAIT;
      r_main_st <= M_IDLE;
      r_tmr     <= '0;
      r_pwr_cnt <= '0;
      r_first   <= 1'b0;
      r_write   <= 1'b0;
      r_bank    <= '0;
      r_row     <= '0;
      r_col     <= '0;
    end else begin
      r_init_st <= w_init_nx;
      r_main_st <= w_main_nx;
      r_first   <= w_change;
      if (w_change)   r_tmr <= w_dwell - TMR_W'(1);
      else if (!w_tc) r_tmr <= r_tmr - TMR_W'(1);
      if (r_init_st == I_WAIT) r_pwr_cnt <= r_pwr_cnt + PWR_W'(1);
      if (w_accept) begin
        r_write <= reqWrite;
        r_col   <= reqAddr[COL_W-1:0];
        r_row   <= reqAddr[COL_W +: ROW_W];
        r_bank  <= reqAddr[COL_W+ROW_W +: BANK_W];
      end
    end
  end

  always_comb begin
    w_init_nx = r_init_st;
    w_main_nx = r_main_st;
    case (r_init_st)
      I_WAIT:  if (r_pwr_cnt == PWR_W'(INIT_WAIT - 1)) w_init_nx = I_CKE;
      I_CKE:   if (w_tc) w_init_nx = I_PRE1;
      I_PRE1:  if (w_tc) w_init_nx = I_EMRS;
      I_EMRS:  if (w_tc) w_init_nx = I_MRS1;
      I_MRS1:  if (w_tc) w_init_nx = I_PRE2;
      I_PRE2:  if (w_tc) w_init_nx = I_REF1;
      I_REF1:  if (w_tc) w_init_nx = I_REF2;
      I_REF2:  if (w_tc) w_init_nx = I_MRS2;
      I_MRS2:  if (w_tc) w_init_nx = I_DONE;
      default: ;
    endcase
    if (w_done) begin
      case (r_main_st)
        M_IDLE:    if (w_ref_pending) w_main_nx = M_REFRESH;
                   else if (reqValid) w_main_nx = M_ACT;
        M_ACT:     if (w_tc) w_main_nx = r_write ? M_WRITE : M_READ;
        M_WRITE:   if (w_tc) w_main_nx = M_RECOVER;
`ifdef AUTO_PRECHARGE_EN
        M_READ:    if (w_tc) w_main_nx = M_RECOVER;
        M_RECOVER: if (w_tc) w_main_nx = M_IDLE;
`else
        M_READ:    if (w_tc) w_main_nx = M_PRE;
        M_RECOVER: if (w_tc) w_main_nx = M_PRE;
`endif
        M_PRE:     if (w_tc) w_main_nx = M_IDLE;
        M_REFRESH: if (w_tc) w_main_nx = M_IDLE;
        default:   w_main_nx = M_IDLE;
      endcase
    end

    // Dwell of the state being entered: its command cycle plus trailing NOPs
    w_dwell = TMR_W'(1);
    if (w_init_nx != r_init_st) begin
      case (w_init_nx)
        I_CKE:                  w_dwell = TMR_W'(2);
        I_PRE1, I_PRE2:         w_dwell = TMR_W'(T_RP);
        I_EMRS, I_MRS1, I_MRS2: w_dwell = TMR_W'(T_MRD);
        I_REF1, I_REF2:         w_dwell = TMR_W'(T_RFC);
        default:                w_dwell = TMR_W'(1);
      endcase
    end else begin
      case (w_main_nx)
        M_ACT:           w_dwell = TMR_W'(T_RCD);
        M_WRITE, M_READ: w_dwell = TMR_W'(HALF_BL);
`ifdef AUTO_PRECHARGE_EN
        M_RECOVER:       w_dwell = r_write ? TMR_W'(T_WR + T_RP) : TMR_W'(T_RP);
`else
        M_RECOVER:       w_dwell = TMR_W'(T_WR);
`endif
        M_PRE:           w_dwell = TMR_W'(T_RP);
        M_REFRESH:       w_dwell = TMR_W'(T_RFC);
        default:         w_dwell = TMR_W'(1);
      endcase
    end
  end

  always_comb begin
    sdCKE    = (r_init_st != I_WAIT);
    sdCS     = (r_init_st == I_WAIT);
    sdCmd    = CMD_NOP;
    sdA      = '0;
    sdBA     = '0;
    reqReady = w_done && (r_main_st == M_IDLE) && !w_ref_pending;
    wrReady  = w_wr_ready;
    initDone = w_done;
    if (r_first) begin
      case (r_init_st)
        I_PRE1, I_PRE2: begin sdCmd = CMD_PRE; sdA[A10] = 1'b1; end
        I_EMRS:         begin sdCmd = CMD_MRS; sdBA = BANK_W'(1); end
        I_MRS1:         begin sdCmd = CMD_MRS; sdA[8] = 1'b1; end
        I_REF1, I_REF2: sdCmd = CMD_REF;
        I_MRS2:         begin sdCmd = CMD_MRS; sdA[6:0] = mode_code(BURST_LEN, CAS_LAT); end
        default: ;
      endcase
      if (w_done) begin
        case (r_main_st)
          M_ACT:     begin sdCmd = CMD_ACT; sdA = r_row; sdBA = r_bank; end
          M_WRITE:   begin sdCmd = CMD_WR; sdA = ROW_W'(r_col); sdA[A10] = AP; sdBA = r_bank; end
          M_READ:    begin sdCmd = CMD_RD; sdA = ROW_W'(r_col); sdA[A10] = AP; sdBA = r_bank; end
          M_PRE:     begin sdCmd = CMD_PRE; sdBA = r_bank; end
          M_REFRESH: sdCmd = CMD_REF;
          default: ;
        endcase
      end
    end
  end

  // Read capture window is the RD burst window shifted by CAS latency
  always_ff @(posedge clk133 or negedge rstN) begin
    if (!rstN) begin
      r_phy_wr_en   <= 1'b0;
      r_phy_wr_data <= '0;
      r_rd_dl       <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
    end else begin
      r_phy_wr_en <= w_wr_ready;
      if (w_wr_ready) r_phy_wr_data <= wrData;
      r_rd_dl    <= {r_rd_dl[CAS_LAT-2:0], w_rd_burst};
      r_rd_valid <= phyRdEn;
      if (phyRdEn) r_rd_data <= phyRdData;
    end
  end

  assign phyWrEn   = r_phy_wr_en;
  assign phyWrData = r_phy_wr_data;
  assign phyRdEn   = r_rd_dl[CAS_LAT-1];
  assign rdValid   = r_rd_valid;
  assign rdData    = r_rd_data;

endmodule

// File: tb/tb_ddr_burst_controller.sv
// Directed self-checking bench for ddr_burst_controller: init sequence, write
// and read bursts, refresh priority/period, and reset during a write burst.
module tb_ddr_burst_controller;

  localparam logic [2:0] NOP = 3'b111, MRS = 3'b000, REF = 3'b001, PRE = 3'b010;
  localparam logic [2:0] ACT = 3'b011, WR = 3'b100, RD = 3'b101;
  localparam int REFI_C = 1040;
`ifdef AUTO_PRECHARGE_EN
  localparam logic [12:0] COL_A10 = 13'h400;
  localparam int NCMD_BURST = 2;
`else
  localparam logic [12:0] COL_A10 = 13'h000;
  localparam int NCMD_BURST = 3;
`endif

  logic        clk133, rstN, reqValid, reqReady, reqWrite;
  logic [24:0] reqAddr;
  logic [31:0] wrData, rdData, phyWrData, phyRdData;
  logic        wrReady, rdValid, initDone, sdCKE, sdCS, phyWrEn, phyRdEn;
  logic [2:0]  sdCmd;
  logic [12:0] sdA;
  logic [1:0]  sdBA;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int d_cyc = 0;
  int ncmd;

  logic [2:0]  e_cmd [7];
  logic [1:0]  e_ba  [7];
  logic [12:0] e_a   [7];
  int          e_off [7];

  logic [2:0]  cmd_log [16];
  logic [12:0] a_log   [16];
  logic [1:0]  ba_log  [16];
  logic [31:0] pwd_log [16];
  logic [31:0] rdd_log [16];
  logic [15:0] rdy_v, wrr_v, pwe_v, pre_v, rv_v;

  ddr_burst_controller dut (
    .clk133(clk133), .rstN(rstN), .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqAddr(reqAddr), .wrData(wrData), .wrReady(wrReady),
    .rdData(rdData), .rdValid(rdValid), .initDone(initDone), .sdCmd(sdCmd),
    .sdA(sdA), .sdBA(sdBA), .sdCKE(sdCKE), .sdCS(sdCS), .phyWrEn(phyWrEn),
    .phyWrData(phyWrData), .phyRdEn(phyRdEn), .phyRdData(phyRdData)
  );

  initial clk133 = 1'b0;
  always #5 clk133 = ~clk133;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk133);
    #1;
    cyc++;
  endtask

  task automatic check_rst_vals(input string tag);
    chk(tag, 128'({sdCKE, sdCS, sdCmd, sdA, sdBA, reqReady, wrReady, rdValid,
                   phyWrEn, phyRdEn, initDone, rdData, phyWrData}),
             128'({1'b0, 1'b1, NOP, 13'd0, 2'd0, 6'd0, 32'd0, 32'd0}));
  endtask

  // Called with the DUT in its first cycle after reset release
  task automatic check_init();
    int n;
    int c0;
    int k;
    n = 0;
    chk("init_cke_low", 128'({sdCKE, sdCS, sdCmd}), 128'({1'b0, 1'b1, NOP}));
    while (sdCKE === 1'b0 && n < 30000) begin
      n++;
      tick();
    end
    chk("init_wait_len", 128'(n), 128'(26600));
    chk("init_cke_cs", 128'({sdCKE, sdCS, sdCmd}), 128'({1'b1, 1'b0, NOP}));
    c0 = cyc;
    k = 0;
    while (initDone !== 1'b1 && cyc - c0 < 60) begin
      if (sdCmd !== NOP) begin
        if (k < 7)
          chk($sformatf("init_cmd%0d", k), 128'({sdCmd, sdBA, sdA, 16'(cyc - c0)}),
              128'({e_cmd[k], e_ba[k], e_a[k], 16'(e_off[k])}));
        k++;
      end
      tick();
    end
    chk("init_ncmd", 128'(k), 128'(7));
    chk("init_done_at", 128'(cyc - c0), 128'(36));
  endtask

  // One request accepted at c=0; logs 16 cycles of outputs
  task automatic run_burst(input logic wr, input logic [24:0] addr);
    for (int c = 0; c < 16; c++) begin
      reqValid  = (c == 0);
      reqWrite  = wr;
      reqAddr   = addr;
      wrData    = (c == 4) ? 32'h1111_1111 : (c == 5) ? 32'h2222_2222 : 32'hDEAD_BEEF;
      phyRdData = 32'hA000_0000 + 32'(c);
      cmd_log[c] = sdCmd;  a_log[c] = sdA;  ba_log[c] = sdBA;
      pwd_log[c] = phyWrData;  rdd_log[c] = rdData;
      rdy_v[c] = reqReady;  wrr_v[c] = wrReady;  pwe_v[c] = phyWrEn;
      pre_v[c] = phyRdEn;   rv_v[c] = rdValid;
      tick();
    end
    reqValid = 1'b0;
    ncmd = 0;
    for (int c = 0; c < 16; c++) if (cmd_log[c] !== NOP) ncmd++;
  endtask

  initial begin
    rstN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0;
    wrData = '0; phyRdData = '0;
    e_cmd = '{PRE, MRS, MRS, PRE, REF, REF, MRS};
    e_ba  = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    e_a   = '{13'h400, 13'h000, 13'h100, 13'h400, 13'h000, 13'h000, 13'h022};
    e_off = '{2, 5, 7, 9, 12, 23, 34};

    repeat (3) @(posedge clk133);
    #1;
    check_rst_vals("rst_vals");
    rstN = 1'b1;
    check_init();
    d_cyc = cyc;
    tick(); tick();

    // Write bank 1 row 5 col 8
    run_burst(1'b1, {2'd1, 13'd5, 10'd8});
    chk("wr_act", 128'({cmd_log[1], ba_log[1], a_log[1]}), 128'({ACT, 2'd1, 13'd5}));
    chk("wr_cmd", 128'({cmd_log[4], ba_log[4], a_log[4]}), 128'({WR, 2'd1, 13'h008 | COL_A10}));
`ifdef AUTO_PRECHARGE_EN
    chk("wr_no_pre", 128'(cmd_log[9]), 128'(NOP));
`else
    chk("wr_pre", 128'({cmd_log[9], ba_log[9], a_log[9]}), 128'({PRE, 2'd1, 13'd0}));
`endif
    chk("wr_ncmd", 128'(ncmd), 128'(NCMD_BURST));
    chk("wr_ready_cyc", 128'(wrr_v), 128'(16'h0030));
    chk("wr_phy_en_cyc", 128'(pwe_v), 128'(16'h0060));
    chk("wr_phy_data", 128'({pwd_log[5], pwd_log[6]}), 128'({32'h1111_1111, 32'h2222_2222}));
    chk("wr_req_ready", 128'(rdy_v), 128'(16'hF001));

    // Read same address
    run_burst(1'b0, {2'd1, 13'd5, 10'd8});
    chk("rd_act", 128'({cmd_log[1], ba_log[1], a_log[1]}), 128'({ACT, 2'd1, 13'd5}));
    chk("rd_cmd", 128'({cmd_log[4], ba_log[4], a_log[4]}), 128'({RD, 2'd1, 13'h008 | COL_A10}));
`ifdef AUTO_PRECHARGE_EN
    chk("rd_no_pre", 128'(cmd_log[6]), 128'(NOP));
`else
    chk("rd_pre", 128'({cmd_log[6], ba_log[6], a_log[6]}), 128'({PRE, 2'd1, 13'd0}));
`endif
    chk("rd_ncmd", 128'(ncmd), 128'(NCMD_BURST));
    chk("rd_phy_en_cyc", 128'(pre_v), 128'(16'h00C0));
    chk("rd_valid_cyc", 128'(rv_v), 128'(16'h0180));
    chk("rd_data", 128'({rdd_log[7], rdd_log[8]}), 128'({32'hA000_0006, 32'hA000_0007}));
    chk("rd_req_ready", 128'(rdy_v), 128'(16'hFE01));

    // Request arrives in the first cycle refresh is pending
    while (cyc < d_cyc + REFI_C) tick();
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = {2'd2, 13'd3, 10'd4};
    chk("ref_blocks_ready", 128'(reqReady), 128'(0));
    rdy_v = '0;
    for (int e = 1; e < 16; e++) begin
      tick();
      if (e == 13) reqValid = 1'b0;
      cmd_log[e] = sdCmd; a_log[e] = sdA; ba_log[e] = sdBA; rdy_v[e] = reqReady;
    end
    chk("ref_first", 128'(cmd_log[1]), 128'(REF));
    chk("ref_ready_gap", 128'(rdy_v[12:1]), 128'(12'h800));
    chk("ref_then_act", 128'({cmd_log[13], ba_log[13], a_log[13]}), 128'({ACT, 2'd2, 13'd3}));
    repeat (20) tick();

    // Second refresh lands one full interval later
    while (sdCmd !== REF && cyc < d_cyc + 2 * REFI_C + 20) tick();
    chk("ref_period", 128'(cyc - d_cyc), 128'(2 * REFI_C + 1));
    repeat (15) tick();

    // Reset during the write data phase
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = {2'd3, 13'd7, 10'd2}; wrData = 32'h3333_3333;
    tick();
    reqValid = 1'b0;
    repeat (4) tick();
    chk("abort_in_burst", 128'({wrReady, phyWrEn, phyWrData}), 128'({1'b1, 1'b1, 32'h3333_3333}));
    rstN = 1'b0;
    #1;
    check_rst_vals("abort_rst_vals");
    tick();
    rstN = 1'b1;
    check_init();
    tick(); tick();
    run_burst(1'b1, {2'd0, 13'd9, 10'd3});
    chk("post_rst_wr", 128'({cmd_log[1], a_log[1], cmd_log[4], a_log[4]}),
        128'({ACT, 13'd9, WR, 13'h003 | COL_A10}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_burst_controller.md
Name: ddr_burst_controller

Overview:
Parametrised single-clock DDR SDRAM command sequencer. It runs the JEDEC power-up/init sequence, then services a request/ready port of burst reads and writes with periodic auto-refresh. It uses a closed-page policy.
It drives command/address pins and word-wide write/read-capture strobes to an external dual-edge IO PHY. Each DATA_W word equals two DDR beats.

Parameters:
ROW_W, 13, row address width (sdA width)
COL_W, 10, column address width
BANK_W, 2, bank address width
DATA_W, 32, user word width (2 x DQ width)
BURST_LEN, 4, DDR beats per burst; legal values 2/4/8
CAS_LAT, 2, CAS latency in clocks; legal values 2/3
T_RP, 3, precharge-to-command clocks
T_MRD, 2, mode-register-set clocks
T_RFC, 11, refresh cycle clocks
T_RCD, 3, activate-to-read/write clocks
T_WR, 3, write recovery clocks
REFI, 1040, clocks between refreshes
INIT_WAIT, 26600, power-up wait clocks (200 us at 133 MHz)

Ports:
clk133  in  1  controller clock; all logic on its rising edge
rstN  in  1  asynchronous active-low reset
reqValid  in  1  request present
reqReady  out  1  request accepted when reqValid && reqReady
reqWrite  in  1  1=write, 0=read
reqAddr  in  BANK_W+ROW_W+COL_W  {bank,row,col}
wrData  in  DATA_W  write word; consumed in a cycle where wrReady=1
wrReady  out  1  one pulse per write word
rdData  out  DATA_W  read word
rdValid  out  1  rdData valid
initDone  out  1  init sequence complete
sdCmd  out  3  {RAS,CAS,WE}, active-low encoding
sdA  out  ROW_W  address bus
sdBA  out  BANK_W  bank address
sdCKE  out  1  clock enable
sdCS  out  1  chip select, active low
phyWrEn  out  1  PHY drives DQ/DQS with phyWrData this cycle
phyWrData  out  DATA_W  registered write word
phyRdEn  out  1  PHY captures DQ this cycle
phyRdData  in  DATA_W  captured word from PHY

Behaviour:
- Reset (async, rstN=0):
  - state INIT_WAIT; sdCKE=0, sdCS=1, sdCmd=NOP (111); sdA=0, sdBA=0.
  - reqReady, wrReady, rdValid, phyWrEn, phyRdEn, initDone = 0; rdData=0, phyWrData=0; counters cleared.
  - Reset mid-burst aborts immediately and the full init sequence reruns.
- Commands: NOP=111, MRS=000, REF=001, PRE=010, ACT=011, WR=100, RD=101. sdCS=0 once CKE rises.
- Every command is followed by NOPs for its timing value minus 1.
- Init sequence, in order:
  - INIT_WAIT: INIT_WAIT cycles with CKE=0, then CKE=1 for 2 NOP cycles.
  - PRE, with A10=1.
  - EMRS: BA=01, A=0 (DLL enable).
  - MRS: BA=00, A8=1 (DLL reset).
  - PRE, with A10=1.
  - REF, then REF.
  - MRS: BA=00, A8=0. A[6:4] is the CAS_LAT code; A[2:0] is the BURST_LEN code (2->001, 4->010, 8->011).
  - initDone rises 1 clock after the final T_MRD and stays high until reset.
- Main FSM states: IDLE, ACT, WRITE, READ, RECOVER, PRE, REFRESH.
- reqReady=1 only in IDLE, when initDone=1 and no refresh is pending.
- On acceptance, ACT is issued the next cycle with row and bank. WR/RD follows T_RCD cycles after ACT, with sdA = column and A10=0.
- Write burst, WR issued at cycle t:
  - wrReady pulses at cycles t..t+BURST_LEN/2-1.
  - phyWrEn=1 at cycles t+1..t+BURST_LEN/2, with phyWrData = wrData registered from the prior cycle.
  - PRE (A10=0, same bank) at t+BURST_LEN/2+T_WR.
- Read burst, RD issued at cycle t:
  - phyRdEn=1 at cycles t+CAS_LAT..t+CAS_LAT+BURST_LEN/2-1.
  - rdValid/rdData are registered from phyRdData, one cycle later.
  - PRE at t+BURST_LEN/2.
- After PRE: T_RP cycles, then IDLE.
- Refresh timer:
  - Counts REFI from initDone and sets refPending at terminal count.
  - In IDLE, refPending has priority over a simultaneous reqValid: REF is issued, T_RFC is waited, refPending clears.
  - The timer restarts at terminal count, so it never drifts because of a burst.
  - A second terminal count while refPending is still set is absorbed (no queueing).
- Address split: col = reqAddr[COL_W-1:0]; row = next ROW_W bits; bank = the top BANK_W bits.

Optional Feature:
AUTO_PRECHARGE_EN
- Defined: WR/RD are issued with A10=1 and no explicit PRE state is used. The FSM waits the equivalent recovery (T_WR+T_RP after a write burst, T_RP after a read burst) on NOPs, then returns to IDLE.
- Undefined: explicit PRE, as above.

Decomposition:
- Package ddr_pkg:
  - command encodings (NOP/MRS/REF/PRE/ACT/WR/RD);
  - FSM state enums for init and main;
  - function mapping BURST_LEN/CAS_LAT to mode-register codes.
- Sub-module ddr_refresh_timer: REFI counter, refPending set/clear, handshake to the main FSM.

Test Plan:
- Reset release, defaults:
  - sdCKE=0 for 26600 cycles.
  - Command order PRE(A10=1), MRS(BA=01), MRS(A=0x100), PRE, REF, REF, MRS(A=0x022), with correct NOP gaps.
  - initDone=1 afterwards.
- Write to bank 1, row 5, col 8, accepted at cycle 0:
  - ACT(BA=1, A=5) at 1; WR(A=8) at 4.
  - wrReady at 4-5; phyWrEn at 5-6 carrying 0x11111111, 0x22222222.
  - PRE at 9; reqReady high again at 12.
- Read, same address, CAS_LAT=2: RD at 4, phyRdEn at 6-7, rdValid at 7-8 echoing phyRdData.
- refPending coincident with reqValid in IDLE: REF is issued first; reqReady stays 0 for T_RFC=11 cycles; the request is then served.
- rstN low during the write data phase: all outputs return to reset values in the same cycle, and the full init sequence replays.
- AUTO_PRECHARGE_EN defined: WR has A10=1, no PRE command appears, and IDLE is reached at the same cycle as the explicit-PRE build.
